// File: rtl/hazard_scoreboard_pkg.sv
// ============================================================================
// Module : hazard_scoreboard_pkg
// Brief  : Shared hazard-tag encodings (forward selects, Tuse/Tnew constants)
//          and match helpers for the pipeline hazard scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_scoreboard_pkg;

  // Forwarding-mux select encodings
  localparam logic [1:0] FWD_GRF   = 2'd0;
  localparam logic [1:0] FWD_E     = 2'd1;
  localparam logic [1:0] FWD_M     = 2'd2;
  localparam logic [1:0] FWD_W     = 2'd3;

  localparam logic [1:0] TUSE_NONE = 2'b11;

  // Tnew as seen when the producer sits in the E stage
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;
  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_IMM  = 2'd0;

  typedef struct packed {
    logic       we;
    logic [4:0] dst;
    logic [1:0] tnew;
  } hz_tag_t;

  // $0 is hard-wired, so it never matches a producer
  function automatic logic tag_hit(input hz_tag_t tag, input logic [4:0] src);
    return tag.we && (tag.dst == src) && (src != 5'd0);
  endfunction

  function automatic logic tag_stall(input hz_tag_t tag, input logic [4:0] src,
                                     input logic [1:0] tuse);
    return tag_hit(tag, src) && (tuse != TUSE_NONE) && (tuse < tag.tnew);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// ============================================================================
// Module : md_busy_counter
// Brief  : Multiply/divide busy countdown; busy while starting or counting.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= is_div ? C_DIV_LOAD : C_MULT_LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign busy = !reset && (start || (r_cnt != '0));

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module : hazard_scoreboard
// Brief  : D/E-stage hazard detection: stall, forward selects, md busy hold.
//          Optional perf counters enabled by HAZARD_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [1:0]  TuseRsD,
  input  logic [1:0]  TuseRtD,
  input  logic        mdUseD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic [1:0]  TnewE,
  input  logic [1:0]  TnewM,
  input  logic [1:0]  TnewW,
  input  logic        mdStartE,
  input  logic        mdIsDivE,
  output logic        stall,
  output logic [1:0]  fwdRsD,
  output logic [1:0]  fwdRtD,
  output logic [1:0]  fwdRsE,
  output logic [1:0]  fwdRtE,
  output logic        mdBusy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stallCount,
  output logic [31:0] mdStallCount
`endif
);

  hz_tag_t w_tag_e, w_tag_m, w_tag_w;
  assign w_tag_e = '{we: RegWriteE, dst: WriteRegE, tnew: TnewE};
  assign w_tag_m = '{we: RegWriteM, dst: WriteRegM, tnew: TnewM};
  assign w_tag_w = '{we: RegWriteW, dst: WriteRegW, tnew: TnewW};

  logic w_md_busy;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (mdStartE),
    .is_div (mdIsDivE),
    .busy   (w_md_busy)
  );

  // W never stalls: its result is already at the register file
  logic w_md_stall;
  logic w_stall;
  assign w_md_stall = mdUseD && w_md_busy;
  assign w_stall    = tag_stall(w_tag_e, rsD, TuseRsD) || tag_stall(w_tag_m, rsD, TuseRsD)
                   || tag_stall(w_tag_e, rtD, TuseRtD) || tag_stall(w_tag_m, rtD, TuseRtD)
                   || w_md_stall;

  // A not-yet-ready nearer producer blocks older ones; the stall covers that case
  logic [1:0] w_fwd_rs_d, w_fwd_rt_d, w_fwd_rs_e, w_fwd_rt_e;
  assign w_fwd_rs_d = tag_hit(w_tag_e, rsD) ? ((TnewE == 2'd0) ? FWD_E : FWD_GRF)
                    : tag_hit(w_tag_m, rsD) ? ((TnewM == 2'd0) ? FWD_M : FWD_GRF)
                    : (tag_hit(w_tag_w, rsD) && (TnewW == 2'd0)) ? FWD_W : FWD_GRF;
  assign w_fwd_rt_d = tag_hit(w_tag_e, rtD) ? ((TnewE == 2'd0) ? FWD_E : FWD_GRF)
                    : tag_hit(w_tag_m, rtD) ? ((TnewM == 2'd0) ? FWD_M : FWD_GRF)
                    : (tag_hit(w_tag_w, rtD) && (TnewW == 2'd0)) ? FWD_W : FWD_GRF;
  assign w_fwd_rs_e = tag_hit(w_tag_m, rsE) ? ((TnewM == 2'd0) ? FWD_M : FWD_GRF)
                    : (tag_hit(w_tag_w, rsE) && (TnewW == 2'd0)) ? FWD_W : FWD_GRF;
  assign w_fwd_rt_e = tag_hit(w_tag_m, rtE) ? ((TnewM == 2'd0) ? FWD_M : FWD_GRF)
                    : (tag_hit(w_tag_w, rtE) && (TnewW == 2'd0)) ? FWD_W : FWD_GRF;

  assign stall  = !reset && w_stall;
  assign mdBusy = w_md_busy;
  assign fwdRsD = reset ? FWD_GRF : w_fwd_rs_d;
  assign fwdRtD = reset ? FWD_GRF : w_fwd_rt_d;
  assign fwdRsE = reset ? FWD_GRF : w_fwd_rs_e;
  assign fwdRtE = reset ? FWD_GRF : w_fwd_rt_e;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_md_stall_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count    <= '0;
      r_md_stall_count <= '0;
    end else begin
      if (stall)      r_stall_count    <= r_stall_count + 32'd1;
      if (w_md_stall) r_md_stall_count <= r_md_stall_count + 32'd1;
    end
  end

  assign stallCount   = r_stall_count;
  assign mdStallCount = r_md_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module : tb_hazard_scoreboard
// Brief  : Directed vector table plus md-countdown and reset sequences.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rsD, rtD, rsE, rtE;
  logic [1:0]  TuseRsD, TuseRtD;
  logic        mdUseD;
  logic        RegWriteE, RegWriteM, RegWriteW;
  logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
  logic [1:0]  TnewE, TnewM, TnewW;
  logic        mdStartE, mdIsDivE;
  logic        stall, mdBusy;
  logic [1:0]  fwdRsD, fwdRtD, fwdRsE, fwdRtE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCount, mdStallCount;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .TuseRsD(TuseRsD), .TuseRtD(TuseRtD), .mdUseD(mdUseD),
    .rsE(rsE), .rtE(rtE),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .TnewE(TnewE), .TnewM(TnewM), .TnewW(TnewW),
    .mdStartE(mdStartE), .mdIsDivE(mdIsDivE),
    .stall(stall), .fwdRsD(fwdRsD), .fwdRtD(fwdRtD), .fwdRsE(fwdRsE), .fwdRtE(fwdRtE),
    .mdBusy(mdBusy)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCount(stallCount), .mdStallCount(mdStallCount)
`endif
  );

  typedef struct {
    logic [4:0] rs_d, rt_d;
    logic [1:0] tuse_rs, tuse_rt;
    logic       md_use;
    logic [4:0] rs_e, rt_e;
    logic       we_e; logic [4:0] wr_e; logic [1:0] tn_e;
    logic       we_m; logic [4:0] wr_m; logic [1:0] tn_m;
    logic       we_w; logic [4:0] wr_w; logic [1:0] tn_w;
    logic       x_stall;
    logic [1:0] x_rs_d, x_rt_d, x_rs_e, x_rt_e;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rsD = 5'd0; rtD = 5'd0; TuseRsD = 2'b11; TuseRtD = 2'b11; mdUseD = 1'b0;
    rsE = 5'd0; rtE = 5'd0;
    RegWriteE = 1'b0; WriteRegE = 5'd0; TnewE = 2'd0;
    RegWriteM = 1'b0; WriteRegM = 5'd0; TnewM = 2'd0;
    RegWriteW = 1'b0; WriteRegW = 5'd0; TnewW = 2'd0;
    mdStartE = 1'b0; mdIsDivE = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    rsD = v.rs_d; rtD = v.rt_d; TuseRsD = v.tuse_rs; TuseRtD = v.tuse_rt; mdUseD = v.md_use;
    rsE = v.rs_e; rtE = v.rt_e;
    RegWriteE = v.we_e; WriteRegE = v.wr_e; TnewE = v.tn_e;
    RegWriteM = v.we_m; WriteRegM = v.wr_m; TnewM = v.tn_m;
    RegWriteW = v.we_w; WriteRegW = v.wr_w; TnewW = v.tn_w;
  endtask

  initial begin
    //          rsD    rtD    tRs   tRt   md    rsE    rtE    E:we wr tn           M:we wr tn           W:we wr tn           stall fRsD fRtD fRsE fRtE
    vecs[0]  = '{5'd1, 5'd2, 2'd0, 2'd0, 1'b0, 5'd3, 5'd4, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[1]  = '{5'd1, 5'd0, 2'd0, 2'd3, 1'b0, 5'd5, 5'd6, 1'b1, 5'd1, 2'd2, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[2]  = '{5'd1, 5'd0, 2'd0, 2'd3, 1'b0, 5'd5, 5'd6, 1'b0, 5'd0, 2'd0, 1'b1, 5'd1, 2'd1, 1'b0, 5'd0, 2'd0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[3]  = '{5'd1, 5'd0, 2'd0, 2'd3, 1'b0, 5'd5, 5'd6, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1, 5'd1, 2'd0, 1'b0, 2'd3, 2'd0, 2'd0, 2'd0};
    vecs[4]  = '{5'd7, 5'd8, 2'd0, 2'd0, 1'b0, 5'd2, 5'd6, 1'b0, 5'd0, 2'd0, 1'b1, 5'd2, 2'd0, 1'b1, 5'd2, 2'd0, 1'b0, 2'd0, 2'd0, 2'd2, 2'd0};
    vecs[5]  = '{5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 2'd2, 1'b1, 5'd0, 2'd1, 1'b1, 5'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[6]  = '{5'd9, 5'd3, 2'd0, 2'd1, 1'b0, 5'd9, 5'd3, 1'b1, 5'd3, 2'd0, 1'b1, 5'd3, 2'd1, 1'b1, 5'd3, 2'd0, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0};
    vecs[7]  = '{5'd4, 5'd10,2'd3, 2'd1, 1'b0, 5'd11,5'd12,1'b1, 5'd4, 2'd2, 1'b1, 5'd10,2'd2, 1'b0, 5'd0, 2'd0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[8]  = '{5'd5, 5'd5, 2'd1, 2'd2, 1'b0, 5'd1, 5'd2, 1'b1, 5'd5, 2'd1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[9]  = '{5'd6, 5'd0, 2'd0, 2'd3, 1'b0, 5'd6, 5'd0, 1'b0, 5'd6, 2'd2, 1'b0, 5'd0, 2'd0, 1'b1, 5'd6, 2'd0, 1'b0, 2'd3, 2'd0, 2'd3, 2'd0};
    vecs[10] = '{5'd7, 5'd0, 2'd0, 2'd3, 1'b0, 5'd7, 5'd7, 1'b0, 5'd0, 2'd0, 1'b1, 5'd7, 2'd0, 1'b1, 5'd7, 2'd0, 1'b0, 2'd2, 2'd0, 2'd2, 2'd2};
    vecs[11] = '{5'd13,5'd14,2'd2, 2'd2, 1'b0, 5'd15,5'd12,1'b1, 5'd12,2'd0, 1'b0, 5'd0, 2'd0, 1'b1, 5'd12,2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd3};
    vecs[12] = '{5'd1, 5'd0, 2'd0, 2'd3, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0};

    // Reset overrides hazard-inducing inputs
    idle();
    reset = 1'b1;
    @(negedge clk);
    apply(vecs[1]);
    RegWriteW = 1'b1; WriteRegW = 5'd5; rsE = 5'd5;
    mdStartE = 1'b1; mdUseD = 1'b1;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mdBusy", {31'd0, mdBusy}, 32'd0);
    check("rst_fwdRsE", {30'd0, fwdRsE}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle();
    mdUseD = 1'b1;
    #1;
    check("post_rst_mdBusy", {31'd0, mdBusy}, 32'd0);
    check("post_rst_stall", {31'd0, stall}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].x_stall});
      check($sformatf("v%0d_fwdRsD", i), {30'd0, fwdRsD}, {30'd0, vecs[i].x_rs_d});
      check($sformatf("v%0d_fwdRtD", i), {30'd0, fwdRtD}, {30'd0, vecs[i].x_rt_d});
      check($sformatf("v%0d_fwdRsE", i), {30'd0, fwdRsE}, {30'd0, vecs[i].x_rs_e});
      check($sformatf("v%0d_fwdRtE", i), {30'd0, fwdRtE}, {30'd0, vecs[i].x_rt_e});
    end

    // div started at cycle 0, mflo waits from cycle 1: busy 1..10, free at 11
    @(negedge clk);
    idle();
    mdStartE = 1'b1; mdIsDivE = 1'b1;
    #1;
    check("div_start_busy", {31'd0, mdBusy}, 32'd1);
    check("div_start_stall", {31'd0, stall}, 32'd0);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      mdStartE = 1'b0; mdIsDivE = 1'b0; mdUseD = 1'b1;
      #1;
      check($sformatf("div_c%0d_busy", c), {31'd0, mdBusy}, (c <= 10) ? 32'd1 : 32'd0);
      check($sformatf("div_c%0d_stall", c), {31'd0, stall}, (c <= 10) ? 32'd1 : 32'd0);
    end

    // mult: busy through cycle 5, free at 6
    @(negedge clk);
    idle();
    mdStartE = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      mdStartE = 1'b0; mdUseD = 1'b1;
      #1;
      check($sformatf("mult_c%0d_stall", c), {31'd0, stall}, (c <= 5) ? 32'd1 : 32'd0);
    end

    // mult, then reset two cycles later
    @(negedge clk);
    idle();
    mdStartE = 1'b1;
    @(negedge clk);
    mdStartE = 1'b0; mdUseD = 1'b1;
    #1;
    check("mrst_c1_busy", {31'd0, mdBusy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mrst_in_rst_busy", {31'd0, mdBusy}, 32'd0);
    check("mrst_in_rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mrst_after_busy", {31'd0, mdBusy}, 32'd0);
    check("mrst_after_stall", {31'd0, stall}, 32'd0);

`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(negedge clk);
    reset = 1'b0;
    apply(vecs[1]);
    repeat (3) @(negedge clk);
    idle();
    #1;
    check("perf_stallCount", stallCount, 32'd3);
    check("perf_mdStallCount", mdStallCount, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("perf_clr_stallCount", stallCount, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
